keypad_scanner: RTL and testbench

- Input-side counterpart of the 4-digit multiplexed seven-segment driver: scans a 4x4 matrix keypad by time-multiplexing active-low row strobes and reading active-low column returns.
- Debounces each full sweep and emits a one-cycle key event plus a held level.
- Feeds the control/ALU front end with 4-bit key codes 0x0-0xF.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_debounce.sv | 140 ++++++++++++++
 rtl/keypad_scanner.sv | 119 +++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debouncer.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
    localparam int unsigned COL_W    = $clog2(NUM_COLS);
    localparam int unsigned CODE_W   = ROW_W + COL_W;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } sweep_result_t;

    typedef enum logic {
        ST_RELEASED,
        ST_PRESSED
    } deb_state_t;

    function automatic logic [CODE_W-1:0] key_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-sweep debounce FSM: match counter, pressed/released state and key outputs.
// AUTO_REPEAT_EN enables periodic repeat pulses while a key stays pressed.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = 3,
    parameter int unsigned REPEAT_SWEEPS  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sweep_valid_i,
    input  sweep_result_t     sweep_res_i,
    input  logic [CODE_W-1:0] sweep_code_i,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_held_o
);

    localparam int unsigned MATCH_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_COUNT);
    localparam int unsigned REP_W = (REPEAT_SWEEPS > 1) ? $clog2(REPEAT_SWEEPS) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SWEEPS - 1);

`ifdef AUTO_REPEAT_EN
    localparam bit RepeatOn = 1'b1;
`else
    localparam bit RepeatOn = 1'b0;
`endif

    deb_state_t          state_q, state_d;
    sweep_result_t       last_res_q, last_res_d;
    logic [CODE_W-1:0]   last_code_q, last_code_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                held_q, held_d;
    logic [REP_W-1:0]    rep_q, rep_d;

    sweep_result_t       eff_res;
    logic                same;
    logic [MATCH_W-1:0]  match_next;
    logic                stable;

    always_comb begin
        state_d     = state_q;
        last_res_d  = last_res_q;
        last_code_d = last_code_q;
        match_d     = match_q;
        code_d      = code_q;
        valid_d     = 1'b0;
        held_d      = held_q;
        rep_d       = rep_q;

        // A different key while pressed is treated as a release; rollover needs a release.
        eff_res = sweep_res_i;
        if (state_q == ST_PRESSED && sweep_res_i == RES_KEY && sweep_code_i != code_q) begin
            eff_res = RES_NONE;
        end

        same = (eff_res == last_res_q) && (eff_res != RES_KEY || sweep_code_i == last_code_q);
        if (!same) begin
            match_next = MATCH_W'(1);
        end else if (match_q == MATCH_MAX) begin
            match_next = match_q;
        end else begin
            match_next = match_q + 1'b1;
        end
        stable = (match_next == MATCH_MAX);

        if (sweep_valid_i) begin
            last_res_d  = eff_res;
            last_code_d = sweep_code_i;
            match_d     = match_next;
            unique case (state_q)
                ST_RELEASED: begin
                    if (eff_res == RES_KEY && stable) begin
                        code_d  = sweep_code_i;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        rep_d   = '0;
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (eff_res == RES_NONE && stable) begin
                        held_d  = 1'b0;
                        state_d = ST_RELEASED;
                    end
                    if (eff_res == RES_KEY) begin
                        if (rep_q == REP_LAST) begin
                            rep_d   = '0;
                            valid_d = RepeatOn;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        rep_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RELEASED;
            last_res_q  <= RES_NONE;
            last_code_q <= '0;
            match_q     <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
            rep_q       <= '0;
        end else if (!en) begin
            // key_code is kept across a disable; everything else restarts.
            state_q     <= ST_RELEASED;
            last_res_q  <= RES_NONE;
            last_code_q <= '0;
            match_q     <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
            rep_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_res_q  <= last_res_d;
            last_code_q <= last_code_d;
            match_q     <= match_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
            rep_q       <= rep_d;
        end
    end

    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, settled column sampling, sweep classification.
// Build option AUTO_REPEAT_EN (see keypad_debounce) adds repeat events while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 30000,
    parameter int unsigned DEBOUNCE_COUNT = 3,
    parameter int unsigned REPEAT_SWEEPS  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_COLS-1:0] col_i,
    output logic [NUM_ROWS-1:0] row_o,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int unsigned TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ROW_W-1:0]  row_q, row_d;
    // Saturating press count for the current sweep: 0, 1, or 2 meaning "two or more".
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;

    logic              active;
    logic              sample;
    logic              sweep_end;
    logic [1:0]        row_hits;
    logic [COL_W-1:0]  hit_col;
    logic [2:0]        acc_sum;
    logic [1:0]        cnt_new;
    logic [CODE_W-1:0] code_new;
    sweep_result_t     sweep_res;

    assign active    = en && !rst;
    assign sample    = active && (tick_q == TICK_LAST);
    assign sweep_end = sample && (row_q == ROW_LAST);
    assign row_o     = active ? ~(ROW_ONE << row_q) : '1;

    always_comb begin
        row_hits = 2'd0;
        hit_col  = '0;
        for (int c = 0; c < int'(NUM_COLS); c++) begin
            if (!col_i[c]) begin
                hit_col = COL_W'(c);
                if (row_hits != 2'd2) begin
                    row_hits = row_hits + 2'd1;
                end
            end
        end
    end

    always_comb begin
        acc_sum  = {1'b0, acc_cnt_q} + {1'b0, row_hits};
        cnt_new  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        code_new = (row_hits != 2'd0) ? key_index(row_q, hit_col) : acc_code_q;

        if (cnt_new == 2'd0) begin
            sweep_res = RES_NONE;
        end else if (cnt_new == 2'd1) begin
            sweep_res = RES_KEY;
        end else begin
            sweep_res = RES_MULTI;
        end

        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (sweep_end) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = '0;
        end else if (sample) begin
            acc_cnt_d  = cnt_new;
            acc_code_d = code_new;
        end

        tick_d = tick_q + 1'b1;
        row_d  = row_q;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            row_d  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            tick_q     <= '0;
            row_q      <= '0;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else begin
            tick_q     <= tick_d;
            row_q      <= row_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
        .REPEAT_SWEEPS  (REPEAT_SWEEPS)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sweep_valid_i (sweep_end),
        .sweep_res_i   (sweep_res),
        .sweep_code_i  (code_new),
        .key_code_o    (key_code),
        .key_valid_o   (key_valid),
        .key_held_o    (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix (SCAN_TICKS=4, 3 sweeps).
module tb_keypad_scanner;

    localparam int unsigned ST    = 4;
    localparam int unsigned DC    = 3;
    localparam int          SWEEP = 4 * ST;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] mask;
        int          sweeps;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic        exp_held;
    } vec_t;

    vec_t vecs[$];

    keypad_scanner #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_COUNT (DC),
        .REPEAT_SWEEPS  (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .col_i     (col_i),
        .row_o     (row_o),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_o[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) col_i[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_sweeps(input int n, output int pulses, output int last_idx);
        pulses   = 0;
        last_idx = -1;
        for (int i = 1; i <= SWEEP * n; i++) begin
            @(posedge clk);
            #1;
            if (key_valid) begin
                pulses++;
                last_idx = i;
            end
        end
    endtask

    initial begin
        int          p;
        int          idx;
        logic [3:0]  exp_row;

        vecs.push_back('{16'h0200, 3, 1, 4'h9, 1'b1});
        vecs.push_back('{16'h0200, 4, 0, 4'h9, 1'b1});
        vecs.push_back('{16'h0000, 2, 0, 4'h9, 1'b1});
        vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0200, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0200, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0200, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0021, 5, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0020, 2, 0, 4'h9, 1'b0});
        vecs.push_back('{16'h0020, 1, 1, 4'h5, 1'b1});
        vecs.push_back('{16'h0400, 3, 0, 4'h5, 1'b0});
        vecs.push_back('{16'h0400, 2, 0, 4'h5, 1'b0});
        vecs.push_back('{16'h0400, 1, 1, 4'hA, 1'b1});
        vecs.push_back('{16'h0000, 3, 0, 4'hA, 1'b0});
        vecs.push_back('{16'h8000, 3, 1, 4'hF, 1'b1});
        vecs.push_back('{16'h0000, 3, 0, 4'hF, 1'b0});

        // Reset with en high: reset wins.
        rst     = 1'b1;
        en      = 1'b1;
        pressed = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset row_o", row_o, 4'hF);
        check("reset key_code", key_code, 4'h0);
        check("reset key_valid", key_valid, 1'b0);
        check("reset key_held", key_held, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first enabled cycle row_o", row_o, 4'hE);

        // Two idle sweeps: row strobe walk, no events.
        p = 0;
        for (int i = 1; i <= 2 * SWEEP; i++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((i / ST) % 4));
            check($sformatf("row_o walk cycle %0d", i), row_o, exp_row);
            if (key_valid) p++;
        end
        check("idle key_valid pulses", p, 0);

        foreach (vecs[v]) begin
            pressed = vecs[v].mask;
            run_sweeps(vecs[v].sweeps, p, idx);
            check($sformatf("vec%0d pulses", v), p, vecs[v].exp_pulses);
            check($sformatf("vec%0d key_code", v), key_code, vecs[v].exp_code);
            check($sformatf("vec%0d key_held", v), key_held, vecs[v].exp_held);
            if (vecs[v].exp_pulses == 1) begin
                check($sformatf("vec%0d pulse cycle", v), idx, SWEEP * vecs[v].sweeps);
            end
        end

        // en dropped after two matching sweeps: debounce must start over.
        pressed = 16'h0008;
        run_sweeps(2, p, idx);
        check("pre-disable pulses", p, 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("disabled row_o", row_o, 4'hF);
        check("disabled key_held", key_held, 1'b0);
        check("disabled key_code holds", key_code, 4'hF);
        @(negedge clk);
        en = 1'b1;
        #1;
        check("re-enable row_o", row_o, 4'hE);
        run_sweeps(2, p, idx);
        check("after re-enable 2 sweeps pulses", p, 0);
        run_sweeps(1, p, idx);
        check("after re-enable 3rd sweep pulses", p, 1);
        check("after re-enable key_code", key_code, 4'h3);
        check("after re-enable key_held", key_held, 1'b1);

        // en dropped while pressed: held clears, key is re-accepted after a full debounce.
        en = 1'b0;
        @(posedge clk);
        #1;
        check("disable while held key_held", key_held, 1'b0);
        check("disable while held key_code", key_code, 4'h3);
        @(negedge clk);
        en = 1'b1;
        run_sweeps(3, p, idx);
        check("reaccept pulses", p, 1);
        check("reaccept pulse cycle", idx, 3 * SWEEP);

        // Reset after two matching sweeps.
        pressed = 16'h0000;
        run_sweeps(3, p, idx);
        check("release before reset key_held", key_held, 1'b0);
        pressed = 16'h0008;
        run_sweeps(2, p, idx);
        check("pre-reset pulses", p, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset row_o", row_o, 4'hF);
        check("mid reset key_code", key_code, 4'h0);
        check("mid reset key_held", key_held, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_sweeps(2, p, idx);
        check("after reset 2 sweeps pulses", p, 0);
        run_sweeps(1, p, idx);
        check("after reset 3rd sweep pulses", p, 1);
        check("after reset key_code", key_code, 4'h3);
        check("after reset key_held", key_held, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
